wb_ram_arbiter: RTL and testbench
=================================

WB_RAM_ARBITER -- requirements
Module: wb_ram_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, RAM word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, RAM address width.
REQ-003 SHALL have port clk  input  1  single clock for all logic (same clock as the RAM read/write port).
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports m0_cyc_i, m0_stb_i, m0_we_i  input  1 each  Wishbone classic cycle, strobe and write-enable from master 0.
REQ-006 SHALL have ports m0_adr_i  input  ADDR_WIDTH and m0_dat_i  input  DATA_WIDTH  master 0 address and write data.
REQ-007 SHALL have ports m0_dat_o  output  DATA_WIDTH and m0_ack_o  output  1  master 0 read data and acknowledge.
REQ-008 SHALL have the identical port set m1_* for master 1.
REQ-009 SHALL have ports ram_addr  output  ADDR_WIDTH, ram_we  output  1, ram_wdat  output  DATA_WIDTH  to the RAM read/write port.
REQ-010 SHALL have port ram_rdat  input  DATA_WIDTH  RAM registered read data (valid 1 cycle after address; returns pre-write contents).
REQ-011 SHALL have port grant  output  2  one-hot current owner (bit0 = m0, bit1 = m1), 2'b00 when idle.

Function
REQ-012 SHALL run an FSM with states IDLE, ACCESS, ACK.
REQ-013 A request from master n SHALL be mn_cyc_i & mn_stb_i.
REQ-014 IDLE: if no request, stay; else on the next edge register winner into grant, latch its adr/we/dat into ram_addr/ram_we/ram_wdat, and go to ACCESS.
REQ-015 ACCESS SHALL last exactly one cycle; ram_we SHALL be high only in ACCESS and only for a write; next state ACK.
REQ-016 ACK SHALL last exactly one cycle; mn_ack_o of the granted master SHALL be high in ACK iff its cyc & stb are still high; next state IDLE with grant = 2'b00.
REQ-017 On a read, mn_dat_o SHALL be loaded from ram_rdat at the ACCESS->ACK edge and held until the next read ack of that master; writes SHALL NOT change mn_dat_o.
REQ-018 Latency: request sampled at edge k -> ack high during cycle k+2; minimum 3 cycles per transfer; back-to-back requests from one master serviced every 3 cycles.
REQ-019 Both masters requesting in IDLE: winner per REQ-027/REQ-028; loser SHALL keep waiting, never lose its request.
REQ-020 Master dropping cyc or stb during ACCESS: the RAM operation SHALL complete (write not cancelled); ack suppressed per REQ-016.
REQ-021 The non-granted master's ack SHALL be 0 at all times.
REQ-022 ram_addr and ram_wdat SHALL hold their last values outside ACCESS; ram_we SHALL be 0 outside ACCESS.

Reset
REQ-023 rst_n low SHALL immediately force state IDLE, grant 2'b00, ram_we 0, m0_ack_o/m1_ack_o 0.
REQ-024 rst_n low SHALL clear ram_addr, ram_wdat, m0_dat_o, m1_dat_o to 0 and the priority pointer to master 0.
REQ-025 Reset asserted in ACCESS SHALL abort the write (ram_we drops before the next clk edge); no ack SHALL be issued for the aborted transfer.
REQ-026 First edge after rst_n deassert SHALL be a normal IDLE evaluation.

Configuration
REQ-027 With macro WB_ARB_ROUND_ROBIN_EN defined: a one-bit pointer SHALL name the preferred master; on simultaneous requests the preferred one wins; the pointer SHALL flip to the other master on every IDLE->ACCESS transition.
REQ-028 Without WB_ARB_ROUND_ROBIN_EN: fixed priority, master 0 SHALL always win simultaneous requests; no pointer register exists.

Verification
REQ-029 Reset, m0 write adr 8'h10 dat 8'hA5 -> ram_we high one cycle with ram_addr 8'h10, ram_wdat 8'hA5; m0_ack_o high 2 cycles after request sampled.
REQ-030 m1 read adr 8'h10 after REQ-029 -> m1_dat_o = 8'hA5 with m1_ack_o; m0_dat_o unchanged 8'h00.
REQ-031 Both masters request continuously (RR enabled) -> grant sequence 01,10,01,10; each ack every 6 cycles; (RR disabled) -> m1 never granted while m0 requests.
REQ-032 m0 write 8'h3C to 8'h20, drop stb during ACCESS -> RAM[8'h20] = 8'h3C, m0_ack_o stays 0.
REQ-033 rst_n low during ACCESS of write 8'hFF to 8'h05 -> ram_we low before next edge, RAM[8'h05] unchanged, all outputs at reset values.

Source files
------------

// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone classic arbiter in front of a single-port synchronous RAM.
// Optional round-robin arbitration via macro WB_ARB_ROUND_ROBIN_EN (default: fixed priority, m0 wins).
module wb_ram_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m0_cyc_i,
   input  logic                  m0_stb_i,
   input  logic                  m0_we_i,
   input  logic [ADDR_WIDTH-1:0] m0_adr_i,
   input  logic [DATA_WIDTH-1:0] m0_dat_i,
   output logic [DATA_WIDTH-1:0] m0_dat_o,
   output logic                  m0_ack_o,
   input  logic                  m1_cyc_i,
   input  logic                  m1_stb_i,
   input  logic                  m1_we_i,
   input  logic [ADDR_WIDTH-1:0] m1_adr_i,
   input  logic [DATA_WIDTH-1:0] m1_dat_i,
   output logic [DATA_WIDTH-1:0] m1_dat_o,
   output logic                  m1_ack_o,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic [DATA_WIDTH-1:0] ram_wdat,
   input  logic [DATA_WIDTH-1:0] ram_rdat,
   output logic [1:0]            grant
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] ACK    = 2'd2;

   logic [1:0]            state;
   logic                  xfer_we;
   logic [DATA_WIDTH-1:0] dat0_q;
   logic [DATA_WIDTH-1:0] dat1_q;
   logic                  req0;
   logic                  req1;
   logic                  pick1;

   // Handshake: a master requests while cyc & stb are high; it is acked for
   // exactly one cycle (ACK state) and only if it still requests then.
   assign req0 = m0_cyc_i & m0_stb_i;
   assign req1 = m1_cyc_i & m1_stb_i;

`ifdef WB_ARB_ROUND_ROBIN_EN
   logic prio_ptr;

   assign pick1 = req1 & (~req0 | prio_ptr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prio_ptr <= 1'b0;
      end else if (state == IDLE && (req0 || req1)) begin
         prio_ptr <= ~prio_ptr;
      end
   end
`else
   assign pick1 = req1 & ~req0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         grant    <= 2'b00;
         ram_addr <= '0;
         ram_wdat <= '0;
         xfer_we  <= 1'b0;
         dat0_q   <= '0;
         dat1_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  grant    <= pick1 ? 2'b10 : 2'b01;
                  ram_addr <= pick1 ? m1_adr_i : m0_adr_i;
                  ram_wdat <= pick1 ? m1_dat_i : m0_dat_i;
                  xfer_we  <= pick1 ? m1_we_i : m0_we_i;
                  state    <= ACCESS;
               end
            end
            ACCESS: begin
               state <= ACK;
            end
            ACK: begin
               // Read data arrives from the RAM during ACK; keep it afterwards.
               if (m0_ack_o && !xfer_we) dat0_q <= ram_rdat;
               if (m1_ack_o && !xfer_we) dat1_q <= ram_rdat;
               grant <= 2'b00;
               state <= IDLE;
            end
            default: begin
               grant <= 2'b00;
               state <= IDLE;
            end
         endcase
      end
   end

   // Combinational from state so an asynchronous reset drops the strobe at once.
   assign ram_we   = (state == ACCESS) & xfer_we;
   assign m0_ack_o = (state == ACK) & grant[0] & req0;
   assign m1_ack_o = (state == ACK) & grant[1] & req1;

   // The RAM's registered read data is only valid during ACK, so it is passed
   // straight through with the ack and held in dat*_q from then on.
   assign m0_dat_o = (m0_ack_o && !xfer_we) ? ram_rdat : dat0_q;
   assign m1_dat_o = (m1_ack_o && !xfer_we) ? ram_rdat : dat1_q;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Bench for wb_ram_arbiter: RAM model, master driver tasks, scoreboard monitor, summary.
module tb_wb_ram_arbiter;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int N_ARB = 4;
  localparam int N_RND = 25;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          m0_cyc_i, m0_stb_i, m0_we_i;
  logic [AW-1:0] m0_adr_i;
  logic [DW-1:0] m0_dat_i, m0_dat_o;
  logic          m0_ack_o;
  logic          m1_cyc_i, m1_stb_i, m1_we_i;
  logic [AW-1:0] m1_adr_i;
  logic [DW-1:0] m1_dat_i, m1_dat_o;
  logic          m1_ack_o;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdat;
  logic [DW-1:0] ram_rdat;
  logic [1:0]    grant;

  wb_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdat(ram_wdat), .ram_rdat(ram_rdat),
    .grant(grant)
  );

  // RAM: write on edge, registered read returning pre-write contents.
  logic [DW-1:0] mem [256];
  logic          mem_init;

  function automatic logic [DW-1:0] pat(input int i);
    return 8'((i * 7) + 3);
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= pat(i);
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdat;
      ram_rdat <= mem[ram_addr];
    end
  end

  // Reference model and scoreboard state.
  logic [DW-1:0]    ref_mem [256];
  logic [DW-1:0]    last_rd [2];
  logic [DW-1:0]    exp0_q[$];
  logic [DW-1:0]    exp1_q[$];
  logic [AW+DW-1:0] wq0[$];
  logic [AW+DW-1:0] wq1[$];
  logic [1:0]       gseq[$];
  int               ack_t0[$];
  int               n_checks = 0;
  int               n_pass = 0;
  int               cyc_cnt = 0;
  bit               log_en = 1'b0;
  logic [1:0]       prev_grant = 2'b00;

  always @(posedge clk) cyc_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: compare every ack and every RAM write against the expected queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m0_ack_o) begin
        check("m0_ack_owner", grant, 2'b01);
        if (exp0_q.size() == 0) begin
          n_checks++;
          $display("FAIL m0_unexpected_ack: got ack=1, required no ack (t=%0t)", $time);
        end else check("m0_dat", m0_dat_o, exp0_q.pop_front());
        if (log_en) ack_t0.push_back(cyc_cnt);
      end
      if (m1_ack_o) begin
        check("m1_ack_owner", grant, 2'b10);
        if (exp1_q.size() == 0) begin
          n_checks++;
          $display("FAIL m1_unexpected_ack: got ack=1, required no ack (t=%0t)", $time);
        end else check("m1_dat", m1_dat_o, exp1_q.pop_front());
      end
      if (ram_we) begin
        if (grant == 2'b01 && wq0.size() > 0) check("m0_ram_write", {ram_addr, ram_wdat}, wq0.pop_front());
        else if (grant == 2'b10 && wq1.size() > 0) check("m1_ram_write", {ram_addr, ram_wdat}, wq1.pop_front());
        else begin
          n_checks++;
          $display("FAIL ram_write_unexpected: got grant=%b adr=%0h dat=%0h, required a pending write", grant, ram_addr, ram_wdat);
        end
      end
      if (log_en && grant != 2'b00 && prev_grant == 2'b00) gseq.push_back(grant);
      prev_grant = grant;
    end else begin
      prev_grant = 2'b00;
    end
  end

  task automatic drop(input int m);
    if (m == 0) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
    else begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
  endtask

  // Issue a request and push what the master must see with its ack.
  task automatic issue(input int m, input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    logic [DW-1:0] e;
    if (we) begin
      ref_mem[adr] = dat;
      e = last_rd[m];
      if (m == 0) wq0.push_back({adr, dat}); else wq1.push_back({adr, dat});
    end else begin
      e = ref_mem[adr];
      last_rd[m] = e;
    end
    if (m == 0) begin
      exp0_q.push_back(e);
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat;
    end else begin
      exp1_q.push_back(e);
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat;
    end
  endtask

  task automatic m_xfer(input int m, input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    bit got = 1'b0;
    issue(m, we, adr, dat);
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = (m == 0) ? m0_ack_o : m1_ack_o;
    end
    if (!got) begin
      n_checks++;
      $display("FAIL ack_timeout_m%0d: got no ack in 60 cycles, required ack", m);
    end
    @(posedge clk); #1;
    drop(m);
  endtask

  task automatic m_loop(input int m, input int n, input bit gaps);
    logic [AW-1:0] adr;
    for (int i = 0; i < n; i++) begin
      adr = (m == 0) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(128, 255));
      m_xfer(m, 1'($urandom_range(0, 1)), adr, 8'($urandom));
      if (gaps) repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, grant, 2'b00);
    check({tag, "_ram_we"}, ram_we, 1'b0);
    check({tag, "_acks"}, {m0_ack_o, m1_ack_o}, 2'b00);
    check({tag, "_ram_addr"}, ram_addr, 8'h00);
    check({tag, "_ram_wdat"}, ram_wdat, 8'h00);
    check({tag, "_dat_o"}, {m0_dat_o, m1_dat_o}, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nack;
    int bad;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = 0; m0_dat_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = 0; m1_dat_i = 0;
    rst_n = 1'b0;
    mem_init = 1'b1;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    repeat (2) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // m0 write 0x10 <= 0xA5: ram_we one cycle after sampling, ack the cycle after.
    issue(0, 1'b1, 8'h10, 8'hA5);
    @(posedge clk);
    @(negedge clk);
    check("wr_ram_we", ram_we, 1'b1);
    check("wr_ram_addr", ram_addr, 8'h10);
    check("wr_ram_wdat", ram_wdat, 8'hA5);
    check("wr_grant", grant, 2'b01);
    check("wr_no_early_ack", m0_ack_o, 1'b0);
    @(negedge clk);
    check("wr_ack", m0_ack_o, 1'b1);
    check("wr_we_low_in_ack", ram_we, 1'b0);
    @(posedge clk); #1;
    drop(0);
    @(negedge clk);
    check("wr_idle_grant", grant, 2'b00);
    check("wr_hold_addr", ram_addr, 8'h10);
    @(posedge clk); #1;

    // m1 reads back what m0 wrote; m0's read register stays at reset value.
    m_xfer(1, 1'b0, 8'h10, 8'h00);
    check("rd_m1_dat_held", m1_dat_o, 8'hA5);
    check("rd_m0_dat_unchanged", m0_dat_o, 8'h00);

    // m0 write 0x3C to 0x20, stb dropped during ACCESS: write lands, no ack.
    ref_mem[8'h20] = 8'h3C;
    wq0.push_back({8'h20, 8'h3C});
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 8'h20; m0_dat_i = 8'h3C;
    @(posedge clk); #1;
    m0_stb_i = 1'b0;
    nack = 0;
    repeat (3) begin
      @(negedge clk);
      if (m0_ack_o) nack++;
    end
    check("drop_no_ack", nack, 0);
    check("drop_write_mem", mem[8'h20], 8'h3C);
    @(posedge clk); #1;
    drop(0);

    // Reset during ACCESS of write 0xFF to 0x05 aborts it.
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_adr_i = 8'h05; m0_dat_i = 8'hFF;
    @(posedge clk); #1;
    check("abort_in_access", ram_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    drop(0);
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    check("abort_mem_unchanged", mem[8'h05], ref_mem[8'h05]);
    @(posedge clk); #1;

    // Both masters requesting continuously.
    log_en = 1'b1;
    fork
      m_loop(0, N_ARB, 1'b0);
      m_loop(1, N_ARB, 1'b0);
    join
    log_en = 1'b0;
    check("arb_grant_count", gseq.size(), 2 * N_ARB);
    for (int i = 0; i < 2 * N_ARB && i < gseq.size(); i++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
      check($sformatf("arb_grant_%0d", i), gseq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
`else
      check($sformatf("arb_grant_%0d", i), gseq[i], (i < N_ARB) ? 2'b01 : 2'b10);
`endif
    end
    check("arb_m0_acks", ack_t0.size(), N_ARB);
    for (int i = 1; i < ack_t0.size(); i++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
      check($sformatf("arb_m0_period_%0d", i), ack_t0[i] - ack_t0[i-1], 6);
`else
      check($sformatf("arb_m0_period_%0d", i), ack_t0[i] - ack_t0[i-1], 3);
`endif
    end

    // Random concurrent traffic, each master in its own address half.
    fork
      m_loop(0, N_RND, 1'b1);
      m_loop(1, N_RND, 1'b1);
    join
    repeat (4) @(posedge clk);
    #1;
    check("end_exp0_empty", exp0_q.size(), 0);
    check("end_exp1_empty", exp1_q.size(), 0);
    check("end_wq0_empty", wq0.size(), 0);
    check("end_wq1_empty", wq1.size(), 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("end_mem_words_wrong", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
